// File: rtl/core_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package core_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    BRANCH,
    PC,
    ERR
  } state_t;

  // Instruction format codes carried in instr[1:0]
  localparam logic [1:0] FMT_BRANCH = 2'b10;
  localparam logic [1:0] FMT_RSVD   = 2'b11;

  // Watchdog counter width; must hold TIMEOUT-1
  localparam int WDOG_W = 8;

  // True for formats that go through the ALU (EXEC + WB)
  function automatic logic is_alu_fmt(input logic [1:0] fmt);
    return (fmt != FMT_BRANCH) && (fmt != FMT_RSVD);
  endfunction

endpackage

// File: rtl/core_seq_watchdog.sv
// Timeout counter for the sequencer's wait states (FETCH, EXEC).
// Latency: expired is combinational from the count and the waiting input.
// Backpressure: none; counts while waiting is high, holds once at the limit.
module core_seq_watchdog
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count;

  // Limit reached while the awaited input is still low; an arriving input wins
  assign expired = waiting && (count == LIMIT);

  // Clear on wait-state entry, count every cycle spent waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && !expired) begin
      count <= count + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: FETCH -> DECODE -> EXEC/WB or BRANCH -> PC, with watchdog.
// Latency: instr_done in the 5th cycle counting the fetch-accept cycle (4th for branch).
// Backpressure: mem_req held until mem_valid; EXEC waits on alu_done; either wait times out to ERR.
// Optional: define CORE_SEQ_PERF_CNT_EN to build the retired-instruction counter.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_valid,
  input  logic               alu_done,
  output logic               mem_req,
  output logic [INSTR_W-1:0] instr_reg,
  output logic               en_alu,
  output logic               en_wb,
  output logic               en_pc,
  output logic               instr_done,
  output logic               busy,
  output logic               err,
  output logic [15:0]        retired_cnt
);

  state_t state;
  logic   wd_clear;
  logic   wd_wait;
  logic   wd_expired;

  // Watchdog control: clear on entry to FETCH/EXEC, count while the awaited input is low
  always_comb begin
    wd_clear = 1'b0;
    wd_wait  = 1'b0;
    case (state)
      IDLE, PC: wd_clear = run;
      DECODE:   wd_clear = is_alu_fmt(instr_reg[1:0]);
      FETCH:    wd_wait  = !mem_valid;
      EXEC:     wd_wait  = !alu_done;
      default:  ;
    endcase
  end

  core_seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .waiting(wd_wait),
    .expired(wd_expired)
  );

  assign busy = (state != IDLE) && (state != ERR);

  // Sequencer FSM; strobes are registered on the transition into their state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      instr_reg  <= '0;
      mem_req    <= 1'b0;
      en_alu     <= 1'b0;
      en_wb      <= 1'b0;
      en_pc      <= 1'b0;
      instr_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      en_alu     <= 1'b0;
      en_wb      <= 1'b0;
      en_pc      <= 1'b0;
      instr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_valid) begin
            instr_reg <= instr_in;
            state     <= DECODE;
            mem_req   <= 1'b0;
          end else if (wd_expired) begin
            state   <= ERR;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end
        end
        DECODE: begin
          if (instr_reg[1:0] == FMT_BRANCH) begin
            state <= BRANCH;
          end else if (instr_reg[1:0] == FMT_RSVD) begin
            // Reserved format retires as a NOP
            state      <= PC;
            en_pc      <= 1'b1;
            instr_done <= 1'b1;
          end else begin
            state  <= EXEC;
            en_alu <= 1'b1;
          end
        end
        EXEC: begin
          if (alu_done) begin
            state <= WB;
            en_wb <= 1'b1;
          end else if (wd_expired) begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        WB, BRANCH: begin
          state      <= PC;
          en_pc      <= 1'b1;
          instr_done <= 1'b1;
        end
        PC: begin
          // run is only sampled here, so a dropped run lets the instruction finish
          if (run) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= ERR;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORE_SEQ_PERF_CNT_EN
  logic [15:0] perf_cnt;

  // Retired-instruction counter, wraps at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt <= 16'd0;
    end else if (instr_done) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign retired_cnt = perf_cnt;
`else
  assign retired_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: latency, strobes, run drop, watchdog, reset, retire count.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_valid/alu_done driven from the stimulus; every wait is cycle-bounded.
module tb_core_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instr_in;
  logic        mem_valid;
  logic        alu_done;
  logic        mem_req;
  logic [15:0] instr_reg;
  logic        en_alu;
  logic        en_wb;
  logic        en_pc;
  logic        instr_done;
  logic        busy;
  logic        err;
  logic [15:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] vec_instr [4] = '{16'h0001, 16'h0A02, 16'h0003, 16'h1234};
  int          vec_lat   [4] = '{5, 4, 3, 5};
  int          vec_alu   [4] = '{1, 0, 0, 1};
  int          vec_wb    [4] = '{1, 0, 0, 1};

  core_sequencer #(
    .INSTR_W(16),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr_in   (instr_in),
    .mem_valid  (mem_valid),
    .alu_done   (alu_done),
    .mem_req    (mem_req),
    .instr_reg  (instr_reg),
    .en_alu     (en_alu),
    .en_wb      (en_wb),
    .en_pc      (en_pc),
    .instr_done (instr_done),
    .busy       (busy),
    .err        (err),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until mem_req is seen (first FETCH cycle), bounded
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 40) begin
      step();
      n++;
    end
    check(tag, {31'd0, mem_req}, 32'd1);
  endtask

  // Called in the fetch-accept cycle; counts cycles (inclusive) until instr_done
  task automatic measure(output int lat, output int n_alu, output int n_wb, output int n_pc);
    lat = 1; n_alu = 0; n_wb = 0; n_pc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      mem_valid = 1'b0;
      lat++;
      if (en_alu) n_alu++;
      if (en_wb)  n_wb++;
      if (en_pc)  n_pc++;
      if (instr_done) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n_alu, n_wb, n_pc, n;
    reset = 1'b1; run = 1'b0; instr_in = 16'h0; mem_valid = 1'b0; alu_done = 1'b0;
    #12;
    check("rst_mem_req",   {31'd0, mem_req},    32'd0);
    check("rst_instr_reg", {16'd0, instr_reg},  32'd0);
    check("rst_strobes",   {28'd0, en_alu, en_wb, en_pc, instr_done}, 32'd0);
    check("rst_busy",      {31'd0, busy},       32'd0);
    check("rst_err",       {31'd0, err},        32'd0);
    check("rst_retired",   {16'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    run = 1'b1;
    alu_done = 1'b1;

    // Back-to-back directed instructions, immediate mem_valid and alu_done
    for (int v = 0; v < 4; v++) begin
      wait_req($sformatf("v%0d_req", v));
      mem_valid = 1'b1;
      instr_in  = vec_instr[v];
      measure(lat, n_alu, n_wb, n_pc);
      check($sformatf("v%0d_lat", v),   lat,   vec_lat[v]);
      check($sformatf("v%0d_alu", v),   n_alu, vec_alu[v]);
      check($sformatf("v%0d_wb", v),    n_wb,  vec_wb[v]);
      check($sformatf("v%0d_pc", v),    n_pc,  1);
      check($sformatf("v%0d_ireg", v),  {16'd0, instr_reg}, {16'd0, vec_instr[v]});
    end

    // run dropped in EXEC, alu_done arrives 3 cycles after EXEC entry
    alu_done = 1'b0;
    wait_req("drop_req");
    mem_valid = 1'b1;
    instr_in  = 16'h0004;
    step();
    mem_valid = 1'b0;
    step();
    check("drop_en_alu_entry", {31'd0, en_alu}, 32'd1);
    run = 1'b0;
    step();
    check("drop_en_alu_once", {31'd0, en_alu}, 32'd0);
    check("drop_busy_exec",   {31'd0, busy},   32'd1);
    step();
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("drop_en_wb", {31'd0, en_wb}, 32'd1);
    step();
    check("drop_en_pc", {30'd0, en_pc, instr_done}, 32'd3);
    step();
    check("drop_idle_busy", {31'd0, busy}, 32'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req) n++;
      step();
    end
    check("drop_no_req", n, 0);

    // mem_valid on the last allowed cycle (cycle 15 after FETCH entry) wins
    run = 1'b1;
    wait_req("wd_req0");
    for (int i = 0; i < 15; i++) step();
    check("wd15_err",   {31'd0, err},     32'd0);
    check("wd15_req",   {31'd0, mem_req}, 32'd1);
    mem_valid = 1'b1;
    instr_in  = 16'h0003;
    step();
    mem_valid = 1'b0;
    check("wd15_accept", {16'd0, instr_reg}, 32'h0003);
    check("wd15_busy",   {30'd0, busy, err}, 32'd2);

    // mem_valid held low: ERR 16 cycles after FETCH entry
    wait_req("wd_req1");
    for (int i = 0; i < 15; i++) step();
    check("wd_pre_err", {31'd0, err}, 32'd0);
    step();
    check("wd_err",      {31'd0, err},     32'd1);
    check("wd_err_req",  {31'd0, mem_req}, 32'd0);
    check("wd_err_busy", {31'd0, busy},    32'd0);
    mem_valid = 1'b1;
    instr_in  = 16'hBEEF;
    alu_done  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mem_valid = 1'b0;
    check("err_sticky",  {31'd0, err}, 32'd1);
    check("err_strobes", {27'd0, mem_req, en_alu, en_wb, en_pc, instr_done}, 32'd0);
    check("err_ireg",    {16'd0, instr_reg}, 32'h0003);

    // Leave ERR via reset, then reset asynchronously in the middle of WB
    reset = 1'b1;
    #2;
    reset = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);
    wait_req("wbrst_req");
    mem_valid = 1'b1;
    instr_in  = 16'h0001;
    step();
    mem_valid = 1'b0;
    step();
    step();
    check("wbrst_in_wb", {31'd0, en_wb}, 32'd1);
    #2;
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("wbrst_strobes", {27'd0, mem_req, en_alu, en_wb, en_pc, instr_done}, 32'd0);
    check("wbrst_busy",    {30'd0, busy, err}, 32'd0);
    check("wbrst_ireg",    {16'd0, instr_reg}, 32'd0);
    check("wbrst_retired", {16'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // After reset, FETCH only on the first edge with run=1
    step();
    step();
    check("post_rst_idle", {30'd0, mem_req, busy}, 32'd0);
    run = 1'b1;
    step();
    check("post_rst_fetch", {31'd0, mem_req}, 32'd1);

    // Retire three NOPs and check the counter
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("cnt_req%0d", k));
      mem_valid = 1'b1;
      instr_in  = 16'h0003;
      measure(lat, n_alu, n_wb, n_pc);
    end
    run = 1'b0;
    step();
`ifdef CORE_SEQ_PERF_CNT_EN
    check("retired_3", {16'd0, retired_cnt}, 32'd3);
    force dut.perf_cnt = 16'hFFFF;
    #1;
    release dut.perf_cnt;
`else
    check("retired_off", {16'd0, retired_cnt}, 32'd0);
`endif
    run = 1'b1;
    wait_req("wrap_req");
    mem_valid = 1'b1;
    instr_in  = 16'h0003;
    measure(lat, n_alu, n_wb, n_pc);
    run = 1'b0;
    step();
    check("retired_wrap", {16'd0, retired_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
- REQ-001 Parameter: INSTR_W, default 16, instruction width in bits.
- REQ-002 Parameter: TIMEOUT, default 16, maximum cycles waited for mem_valid or alu_done.
- REQ-003 clk  input  1  single core clock; all state changes on its rising edge.
- REQ-004 reset  input  1  reset, asynchronous and active-high.
- REQ-005 run  input  1  level enable for instruction sequencing.
- REQ-006 instr_in  input  INSTR_W  instruction read data from instruction memory.
- REQ-007 mem_valid  input  1  instr_in is valid this cycle.
- REQ-008 alu_done  input  1  ALU completion strobe.
- REQ-009 mem_req  output  1  fetch request, held until accepted.
- REQ-010 instr_reg  output  INSTR_W  latched current instruction.
- REQ-011 en_alu  output  1  one-cycle ALU start strobe.
- REQ-012 en_wb  output  1  one-cycle register-file writeback strobe.
- REQ-013 en_pc  output  1  one-cycle PC update strobe.
- REQ-014 instr_done  output  1  one-cycle instruction-retired strobe.
- REQ-015 busy  output  1  high in every state except IDLE and ERR.
- REQ-016 err  output  1  sticky timeout flag.
- REQ-017 retired_cnt  output  16  retired-instruction count (see Configuration).

Function
- REQ-018 FSM states: IDLE, FETCH, DECODE, EXEC, WB, BRANCH, PC, ERR.
- REQ-019 IDLE: stay while run=0; go to FETCH when run=1.
- REQ-020 FETCH: mem_req=1; on mem_valid, latch instr_in into instr_reg and go to DECODE.
- REQ-021 DECODE (1 cycle), decoded on instr_reg[1:0]:
  - 2'b10 (branch) goes to BRANCH.
  - 2'b11 (reserved) goes to PC as a NOP; no en_alu, no en_wb.
  - Any other value goes to EXEC.
- REQ-022 EXEC: en_alu=1 on the entry cycle only; wait for alu_done, which is accepted on any EXEC cycle including the entry cycle; then go to WB.
- REQ-023 WB: en_wb=1 for one cycle, then go to PC.
- REQ-024 BRANCH: one cycle, no strobes; then go to PC.
- REQ-025 PC: en_pc=1 and instr_done=1 for one cycle; go to FETCH if run=1, else IDLE.
- REQ-026 Deasserting run mid-instruction does not abort the instruction: it completes through PC, then the FSM goes to IDLE.
- REQ-027 Minimum latency, fetch accept to instr_done: non-branch 5 cycles; branch 4 cycles.
- REQ-028 Watchdog counter:
  - Cleared on entry to FETCH or EXEC.
  - Increments each cycle in which the awaited input is low.
  - When the count reaches TIMEOUT-1 with the input still low, the FSM goes to ERR.
  - If mem_valid or alu_done arrives in the same cycle as the limit, it wins: normal transition, no error.
- REQ-029 ERR state:
  - err=1.
  - All strobes and mem_req = 0.
  - ERR is left only by reset.
- REQ-030 instr_reg changes only on a FETCH accept.

Reset
- REQ-031 reset asserted at any time, including mid-instruction: the FSM returns asynchronously to IDLE, and instr_reg, watchdog, retired_cnt, err and every strobe clear to 0.
- REQ-032 After reset deasserts, the first FETCH occurs on the first clock edge at which run=1.

Configuration
- REQ-033 Macro CORE_SEQ_PERF_CNT_EN:
  - Defined: retired_cnt increments on each instr_done and wraps 16'hFFFF to 0.
  - Undefined: retired_cnt is tied to 0 and no counter flops exist.

Structure
- REQ-034 Package core_seq_pkg holds:
  - the state enumeration;
  - format constants FMT_BRANCH=2'b10 and FMT_RSVD=2'b11;
  - the watchdog width constant.
- REQ-035 Sub-module core_seq_watchdog holds the timeout counter: inputs clear and wait, output expired.

Verification
- REQ-036 Scenario: run=1, ALU instruction 16'h0001, mem_valid and alu_done both immediate -> instr_done exactly 5 cycles after the FETCH accept; en_alu, en_wb and en_pc each a single-cycle pulse.
- REQ-037 Scenario: branch 16'h0A02 -> BRANCH path; en_pc 4 cycles after the accept; en_alu and en_wb never asserted.
- REQ-038 Scenario: mem_valid held low, TIMEOUT=16 -> err=1 and state ERR 16 cycles after FETCH entry; mem_valid asserted exactly on cycle 15 -> no err.
- REQ-039 Scenario: run dropped during EXEC with alu_done 3 cycles later -> WB, then PC, then IDLE; no further mem_req.
- REQ-040 Scenario: reset pulsed mid-WB -> all outputs 0 asynchronously; retired_cnt=0.
- REQ-041 Scenario: with CORE_SEQ_PERF_CNT_EN defined, 3 retired instructions -> retired_cnt=3; preloaded at 16'hFFFF, one more retire -> 0.
